ext_access_serializer: RTL

- Sits directly downstream of the SRAM tile buffer's external-access outputs.
- Collects per-requester reads/writes that fall outside the SRAM region and serializes them onto one global-memory port, one transaction at a time.
- Selects among requesters round-robin and returns a one-cycle ready pulse, plus read data, to the originating requester.

---
 rtl/ext_access_serializer_pkg.sv | 8 +
 rtl/ext_access_serializer_if.sv | 40 ++++
 rtl/ext_access_serializer_picker.sv | 22 ++
 rtl/ext_access_serializer.sv | 79 +++++++
 4 files changed

// File: rtl/ext_access_serializer_pkg.sv
// ext_access_pkg: FSM states, op encoding and default widths shared with the tile buffer.
package ext_access_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;
    localparam int DEF_NUM_REQUESTERS = 8;
    localparam int DEF_ADDR_BITS = 11;
    localparam int DEF_DATA_WIDTH = 64;
endpackage

// File: rtl/ext_access_serializer_if.sv
// ext_access_serializer_if: requester-side and global-memory-side signals of the serializer.
interface ext_access_serializer_if import ext_access_pkg::*; #(
    parameter int NUM_REQUESTERS = DEF_NUM_REQUESTERS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_BITS = $clog2(NUM_REQUESTERS)
) ();
    logic [NUM_REQUESTERS-1:0] req_read_valid;
    logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_read_address;
    logic [NUM_REQUESTERS-1:0] req_write_valid;
    logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_write_address;
    logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] req_write_data;
    logic [NUM_REQUESTERS-1:0] req_read_ready;
    logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] req_read_data;
    logic [NUM_REQUESTERS-1:0] req_write_ready;
    logic mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic mem_read_ready;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic mem_write_ready;
    logic busy;
    logic [IDX_BITS-1:0] active_requester;
    modport master (
        input req_read_valid, req_read_address, req_write_valid, req_write_address, req_write_data,
        input mem_read_ready, mem_read_data, mem_write_ready,
        output req_read_ready, req_read_data, req_write_ready,
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        output busy, active_requester
    );
    modport slave (
        output req_read_valid, req_read_address, req_write_valid, req_write_address, req_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input req_read_ready, req_read_data, req_write_ready,
        input mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        input busy, active_requester
    );
endinterface

// File: rtl/ext_access_serializer_picker.sv
// rr_priority_picker: first set request bit searching upward from last+1, wrapping.
module rr_priority_picker #(
    parameter int N = 8,
    parameter int IDX_BITS = $clog2(N)
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] last,
    output logic [IDX_BITS-1:0] grant,
    output logic                any_grant
);
    logic [IDX_BITS-1:0] k;
    // Walk from farthest to nearest so the nearest set bit is the final assignment.
    always_comb begin
        grant = '0;
        k = '0;
        for (int i = N; i >= 1; i--) begin
            k = IDX_BITS'((int'(last) + i) % N);
            if (req[k]) grant = k;
        end
    end
    assign any_grant = |req;
endmodule

// File: rtl/ext_access_serializer.sv
// ext_access_serializer: round-robin serializer of per-lane external reads/writes
// onto a single global-memory port, one transaction at a time.
module ext_access_serializer import ext_access_pkg::*; #(
    parameter int NUM_REQUESTERS = DEF_NUM_REQUESTERS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic clk,
    input logic reset,
    ext_access_serializer_if.master bus
);
    localparam int IDX_BITS = $clog2(NUM_REQUESTERS);
    state_t state, state_nx;
    op_t op;
    logic [IDX_BITS-1:0] idx, rr_last, grant;
    logic any_grant;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NUM_REQUESTERS-1:0] cooldown, pending;
    logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] rdata;

    // The lane that just completed is masked for one IDLE cycle so its still-held valid is not re-issued.
    assign pending = (bus.req_read_valid | bus.req_write_valid) & ~cooldown;

    rr_priority_picker #(.N(NUM_REQUESTERS), .IDX_BITS(IDX_BITS)) picker (
        .req(pending), .last(rr_last), .grant(grant), .any_grant(any_grant)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_grant) state_nx = bus.req_write_valid[grant] ? WR_WAIT : RD_WAIT;
            RD_WAIT: if (bus.mem_read_ready) state_nx = DONE;
            WR_WAIT: if (bus.mem_write_ready) state_nx = DONE;
            DONE:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            idx <= '0;
            op <= OP_READ;
            addr <= '0;
            wdata <= '0;
            rr_last <= IDX_BITS'(NUM_REQUESTERS - 1);
            cooldown <= '0;
            rdata <= '0;
        end else begin
            if (state == IDLE) begin
                cooldown <= '0;
                if (any_grant) begin
                    idx <= grant;
                    op <= bus.req_write_valid[grant] ? OP_WRITE : OP_READ;
                    addr <= bus.req_write_valid[grant] ? bus.req_write_address[grant] : bus.req_read_address[grant];
                    wdata <= bus.req_write_data[grant];
                end
            end
            if (state == RD_WAIT && bus.mem_read_ready) rdata[idx] <= bus.mem_read_data;
            if (state == DONE) begin
                rr_last <= idx;
                cooldown <= NUM_REQUESTERS'(1) << idx;
            end
        end

    assign bus.busy = state != IDLE;
    assign bus.active_requester = bus.busy ? idx : '0;
    assign bus.mem_read_valid = state == RD_WAIT;
    assign bus.mem_read_address = bus.mem_read_valid ? addr : '0;
    assign bus.mem_write_valid = state == WR_WAIT;
    assign bus.mem_write_address = bus.mem_write_valid ? addr : '0;
    assign bus.mem_write_data = bus.mem_write_valid ? wdata : '0;
    assign bus.req_read_ready = (state == DONE && op == OP_READ) ? NUM_REQUESTERS'(1) << idx : '0;
    assign bus.req_write_ready = (state == DONE && op == OP_WRITE) ? NUM_REQUESTERS'(1) << idx : '0;
    assign bus.req_read_data = rdata;
endmodule
